// File: rtl/ct_f_spsram_2048x59_wbctl_if.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_2048x59_wbctl_if
//
// Bundles the request-side and SRAM-side signals of the write-buffered
// SRAM access controller.
//
// Modports:
//   slave  : the controller. It takes write/read requests and sram_q, and
//            drives the ready/status flags, read data and the SRAM pins.
//   master : the surrounding logic, which issues requests and models the
//            SRAM macro.
//
// Signals:
//   wr_vld/wr_addr/wr_data/wr_bmask/wr_rdy : write request channel
//   rd_vld/rd_addr/rd_rdy                  : read request channel
//   rd_data_vld/rd_data                    : read response (one cycle after grant)
//   wb_empty                               : write buffer empty
//   sram_cen/sram_gwen/sram_wen            : active-low SRAM controls
//   sram_a/sram_d/sram_q                   : SRAM address, write data, read data
// ---------------------------------------------------------------------------
interface ct_f_spsram_2048x59_wbctl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 59
);
  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_bmask;
  logic                  wr_rdy;

  logic                  rd_vld;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_rdy;
  logic                  rd_data_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wb_empty;

  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  wr_vld, wr_addr, wr_data, wr_bmask,
    input  rd_vld, rd_addr,
    input  sram_q,
    output wr_rdy, rd_rdy, rd_data_vld, rd_data, wb_empty,
    output sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );

  modport master (
    output wr_vld, wr_addr, wr_data, wr_bmask,
    output rd_vld, rd_addr,
    output sram_q,
    input  wr_rdy, rd_rdy, rd_data_vld, rd_data, wb_empty,
    input  sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );
endinterface

// File: rtl/ct_f_spsram_2048x59_wbctl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_2048x59_wbctl
//
// Write-buffered access controller in front of a 2048x59 single-port SRAM.
// Independent read and write request ports share the one SRAM port. Writes
// land in a small circular FIFO and drain to the SRAM when the port is free
// (or immediately when the FIFO is full). A read whose address matches any
// buffered write stalls until the matching entries have drained, so reads
// always observe every previously accepted write. Read data comes straight
// from sram_q one cycle after the grant.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ct_f_spsram_2048x59_wbctl_if.slave (request, response, SRAM pins)
//
// Parameters:
//   ADDR_WIDTH   : SRAM address width
//   DATA_WIDTH   : SRAM data width
//   WB_DEPTH     : write-buffer entries (power of two, >= 2)
//   STARVE_LIMIT : consecutive read grants tolerated while the buffer holds
//                  data (only with the starvation guard)
//
// Build option:
//   CT_SPSRAM_WB_STARVE_GUARD_EN : when defined, a counter of read grants
//   taken while the buffer is non-empty forces a drain once it reaches
//   STARVE_LIMIT. When undefined no counter exists and reads always win
//   unless the buffer is full or the read hits a buffered address.
// ---------------------------------------------------------------------------
module ct_f_spsram_2048x59_wbctl #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 59,
  parameter int WB_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                       clk,
  input logic                       rst,
  ct_f_spsram_2048x59_wbctl_if.slave bus
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_DEPTH);

  // -------------------------------------------------------------------------
  // Write buffer storage and bookkeeping
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_mem [WB_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [WB_DEPTH];
  logic [DATA_WIDTH-1:0] mask_mem [WB_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic full;
  logic empty;
  logic wr_rdy;
  logic enq;
  logic hit;
  logic starve_trip;
  logic sel_read;
  logic sel_drain;
  logic rd_data_vld_reg;

  logic [WB_DEPTH-1:0] entry_hit;

  assign full   = (count_reg == DEPTH_C);
  assign empty  = (count_reg == '0);
  assign wr_rdy = !full && !rst;
  assign enq    = bus.wr_vld && wr_rdy;

  // -------------------------------------------------------------------------
  // Hit detection: an entry is live when its distance from the head is below
  // the occupancy. Only stored entries are compared, so a write being
  // enqueued this cycle never blocks a read issued in the same cycle.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_hit
      localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
      logic [PTR_W-1:0] age;
      logic             live;
      assign age           = IDX - rd_ptr_reg;
      assign live          = ({1'b0, age} < count_reg);
      assign entry_hit[gi] = live && (addr_mem[gi] == bus.rd_addr);
    end
  endgenerate

  assign hit = |entry_hit;

  // -------------------------------------------------------------------------
  // Starvation guard
  // -------------------------------------------------------------------------
`ifdef CT_SPSRAM_WB_STARVE_GUARD_EN
  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SC_W-1:0] LIMIT_C = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_reg;

  // The counter is only ever non-zero while data is buffered; the empty
  // qualifier keeps the guard from demanding a drain with nothing to drain.
  assign starve_trip = !empty && (starve_cnt_reg >= LIMIT_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (sel_drain || empty) begin
      starve_cnt_reg <= '0;
    end else if (sel_read) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end
`else
  // No guard is built. The limit is folded into a constant-false term so the
  // parameter list stays identical between the two builds.
  assign starve_trip = 1'b0 & (STARVE_LIMIT < 0);
`endif

  // -------------------------------------------------------------------------
  // Port arbitration, highest priority first: full drain, forced drain,
  // non-hitting read, opportunistic drain, idle.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_read  = 1'b0;
    sel_drain = 1'b0;
    if (rst) begin
      sel_read  = 1'b0;
      sel_drain = 1'b0;
    end else if (full) begin
      sel_drain = 1'b1;
    end else if (starve_trip) begin
      sel_drain = 1'b1;
    end else if (bus.rd_vld && !hit) begin
      sel_read = 1'b1;
    end else if (!empty) begin
      sel_drain = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Buffer pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (sel_drain) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({enq, sel_drain})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage carries no reset: stale entries are never live because
  // the occupancy count is cleared.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= bus.wr_addr;
      data_mem[wr_ptr_reg] <= bus.wr_data;
      mask_mem[wr_ptr_reg] <= bus.wr_bmask;
    end
  end

  // -------------------------------------------------------------------------
  // Read response flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_vld_reg <= 1'b0;
    end else begin
      rd_data_vld_reg <= sel_read;
    end
  end

  // -------------------------------------------------------------------------
  // SRAM pin drive
  // -------------------------------------------------------------------------
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (sel_read) begin
      sram_cen = 1'b0;
      sram_a   = bus.rd_addr;
    end else if (sel_drain) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~mask_mem[rd_ptr_reg];
      sram_a    = addr_mem[rd_ptr_reg];
      sram_d    = data_mem[rd_ptr_reg];
    end
  end

  assign bus.sram_cen    = sram_cen;
  assign bus.sram_gwen   = sram_gwen;
  assign bus.sram_wen    = sram_wen;
  assign bus.sram_a      = sram_a;
  assign bus.sram_d      = sram_d;

  assign bus.wr_rdy      = wr_rdy;
  assign bus.rd_rdy      = sel_read;
  assign bus.rd_data_vld = rd_data_vld_reg;
  assign bus.rd_data     = bus.sram_q;
  assign bus.wb_empty    = empty;

endmodule

// File: tb/tb_ct_f_spsram_2048x59_wbctl.sv
// ---------------------------------------------------------------------------
// tb_ct_f_spsram_2048x59_wbctl
//
// Bench for the write-buffered SRAM controller. It models the SRAM macro,
// keeps a reference memory that takes each write at the moment it is
// accepted, and a queue of accepted-but-not-yet-written entries. A negedge
// monitor checks the read data, flags and SRAM drains against these; the
// scenario tasks check their own directed expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ct_f_spsram_2048x59_wbctl;
  localparam int AW    = 11;
  localparam int DW    = 59;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_f_spsram_2048x59_wbctl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_f_spsram_2048x59_wbctl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WB_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // SRAM macro model
  logic [DW-1:0] sram_mem [2048];
  logic [DW-1:0] sram_q_reg = '0;
  assign bus.sram_q = sram_q_reg;

  always @(posedge clk) begin
    if (bus.sram_cen === 1'b0) begin
      if (bus.sram_gwen === 1'b0)
        sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
      else
        sram_q_reg <= sram_mem[bus.sram_a];
    end
  end

  // Reference: memory as seen by requesters, and the pending-write queue
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] m;
  } wb_t;

  logic [DW-1:0] ref_mem [2048];
  wb_t           wq [$];
  logic          pend_vld = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic [AW-1:0] pend_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      wq.delete();
      pend_vld = 1'b0;
    end else begin
      bit hit_m;
      bit exp_drain;
      bit is_drain;
      hit_m = 1'b0;
      foreach (wq[i]) if (wq[i].a == bus.rd_addr) hit_m = 1'b1;

      total++;
      if (bus.rd_data_vld !== pend_vld) begin
        bad++;
        $display("FAIL mon_rd_data_vld actual=%0b required=%0b t=%0t", bus.rd_data_vld, pend_vld, $time);
      end
      if (pend_vld) begin
        total++;
        if (bus.rd_data !== pend_data) begin
          bad++;
          $display("FAIL mon_rd_data addr=%h actual=%h required=%h", pend_addr, bus.rd_data, pend_data);
        end else begin
          $display("rd addr=%h data=%h", pend_addr, bus.rd_data);
        end
      end

      total++;
      if (bus.wr_rdy !== (wq.size() < DEPTH)) begin
        bad++;
        $display("FAIL mon_wr_rdy actual=%0b required=%0b", bus.wr_rdy, (wq.size() < DEPTH));
      end
      total++;
      if (bus.wb_empty !== (wq.size() == 0)) begin
        bad++;
        $display("FAIL mon_wb_empty actual=%0b required=%0b", bus.wb_empty, (wq.size() == 0));
      end

`ifndef CT_SPSRAM_WB_STARVE_GUARD_EN
      total++;
      if (bus.rd_rdy !== (bus.rd_vld && !hit_m && wq.size() < DEPTH)) begin
        bad++;
        $display("FAIL mon_rd_rdy actual=%0b required=%0b", bus.rd_rdy, (bus.rd_vld && !hit_m && wq.size() < DEPTH));
      end
`endif
      if (bus.rd_rdy === 1'b1) begin
        total++;
        if (!bus.rd_vld || hit_m || wq.size() >= DEPTH || bus.sram_cen !== 1'b0 ||
            bus.sram_gwen !== 1'b1 || bus.sram_a !== bus.rd_addr) begin
          bad++;
          $display("FAIL mon_read_grant hit=%0b occ=%0d cen=%0b gwen=%0b a=%h required_a=%h",
                   hit_m, wq.size(), bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.rd_addr);
        end
      end

      exp_drain = (wq.size() > 0) && (bus.rd_rdy !== 1'b1);
      is_drain  = (bus.sram_cen === 1'b0) && (bus.sram_gwen === 1'b0);
      total++;
      if (is_drain !== exp_drain) begin
        bad++;
        $display("FAIL mon_drain_select actual=%0b required=%0b occ=%0d", is_drain, exp_drain, wq.size());
      end
      if (is_drain && wq.size() > 0) begin
        total++;
        if (bus.sram_a !== wq[0].a || bus.sram_d !== wq[0].d || bus.sram_wen !== ~wq[0].m) begin
          bad++;
          $display("FAIL mon_drain_entry actual a=%h d=%h wen=%h required a=%h d=%h wen=%h",
                   bus.sram_a, bus.sram_d, bus.sram_wen, wq[0].a, wq[0].d, ~wq[0].m);
        end
        void'(wq.pop_front());
      end

      // Read is ordered before a same-cycle enqueue.
      pend_vld  = bus.rd_vld && bus.rd_rdy;
      pend_addr = bus.rd_addr;
      pend_data = ref_mem[bus.rd_addr];
      if (bus.wr_vld && bus.wr_rdy) begin
        wb_t e;
        e.a = bus.wr_addr;
        e.d = bus.wr_data;
        e.m = bus.wr_bmask;
        wq.push_back(e);
        ref_mem[e.a] = (ref_mem[e.a] & ~e.m) | (e.d & e.m);
        $display("wr addr=%h data=%h mask=%h", e.a, e.d, e.m);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_vld   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_bmask = '0;
    bus.rd_vld   = 1'b0;
    bus.rd_addr  = '0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic drain_all(input string name);
    bit done = 1'b0;
    drive_idle();
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.wb_empty === 1'b1) done = 1'b1;
      else tick();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain_timeout actual wb_empty=%0b required=1", name, bus.wb_empty);
    end
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    bit got = 1'b0;
    bus.wr_vld  = 1'b0;
    bus.rd_vld  = 1'b1;
    bus.rd_addr = a;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus.rd_rdy === 1'b1) got = 1'b1;
      tick();
    end
    bus.rd_vld = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_grant_timeout actual rd_rdy=%0b required=1", name, bus.rd_rdy);
    end else begin
      @(negedge clk);
      total++;
      if (bus.rd_data_vld !== 1'b1 || bus.rd_data !== exp) begin
        bad++;
        $display("FAIL %s_data actual vld=%0b data=%h required vld=1 data=%h", name, bus.rd_data_vld, bus.rd_data, exp);
      end
      tick();
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.wr_vld   = 1'($urandom());
      bus.wr_addr  = AW'($urandom());
      bus.wr_data  = rnd_data();
      bus.wr_bmask = rnd_data();
      bus.rd_vld   = 1'($urandom());
      bus.rd_addr  = AW'($urandom());
      @(negedge clk);
      total++;
      if (bus.wr_rdy !== 1'b0 || bus.rd_rdy !== 1'b0 || bus.sram_cen !== 1'b1) begin
        bad++;
        $display("FAIL reset_handshake actual wr_rdy=%0b rd_rdy=%0b cen=%0b required 0 0 1", bus.wr_rdy, bus.rd_rdy, bus.sram_cen);
      end
      total++;
      if (bus.rd_data_vld !== 1'b0 || bus.wb_empty !== 1'b1 || bus.sram_gwen !== 1'b1 || bus.sram_wen !== {DW{1'b1}}) begin
        bad++;
        $display("FAIL reset_flags actual vld=%0b empty=%0b gwen=%0b wen=%h", bus.rd_data_vld, bus.wb_empty, bus.sram_gwen, bus.sram_wen);
      end
      tick();
    end
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.wr_rdy !== 1'b1 || bus.wb_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_release actual wr_rdy=%0b wb_empty=%0b required 1 1", bus.wr_rdy, bus.wb_empty);
    end
    tick();
    $display("test_reset complete");
  endtask

  task automatic test_write_hit();
    logic [DW-1:0] d;
    d = 59'h5A5A5A5A5A5A5A5;
    drain_all("hit");
    bus.wr_vld = 1'b1; bus.wr_addr = 11'h123; bus.wr_data = d; bus.wr_bmask = '1;
    @(negedge clk);
    total++;
    if (bus.wr_rdy !== 1'b1 || bus.sram_cen !== 1'b1) begin
      bad++;
      $display("FAIL hit_enqueue actual wr_rdy=%0b cen=%0b required 1 1", bus.wr_rdy, bus.sram_cen);
    end
    tick();
    bus.wr_vld = 1'b0; bus.rd_vld = 1'b1; bus.rd_addr = 11'h123;
    @(negedge clk);
    total++;
    if (bus.rd_rdy !== 1'b0 || bus.sram_cen !== 1'b0 || bus.sram_gwen !== 1'b0 || bus.sram_a !== 11'h123 || bus.sram_d !== d) begin
      bad++;
      $display("FAIL hit_stall_drain actual rd_rdy=%0b cen=%0b gwen=%0b a=%h d=%h required 0 0 0 123 %h",
               bus.rd_rdy, bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_d, d);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.rd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL hit_grant actual rd_rdy=%0b required=1", bus.rd_rdy);
    end
    tick();
    bus.rd_vld = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rd_data_vld !== 1'b1 || bus.rd_data !== d) begin
      bad++;
      $display("FAIL hit_data actual vld=%0b data=%h required 1 %h", bus.rd_data_vld, bus.rd_data, d);
    end
    tick();
    $display("test_write_hit complete");
  endtask

  task automatic test_buffer_full();
    logic [DW-1:0] d0, d1, d2;
    d0 = rnd_data(); d1 = rnd_data(); d2 = rnd_data();
    drain_all("full");
    bus.rd_vld = 1'b1; bus.rd_addr = 11'h010;
    bus.wr_vld = 1'b1; bus.wr_addr = 11'h200; bus.wr_data = d0; bus.wr_bmask = '1;
    @(negedge clk);
    total++;
    if (bus.rd_rdy !== 1'b1) begin
      bad++; $display("FAIL full_c0_read actual rd_rdy=%0b required=1", bus.rd_rdy);
    end
    tick();
    bus.wr_addr = 11'h201; bus.wr_data = d1;
    @(negedge clk);
    total++;
    if (bus.rd_rdy !== 1'b1 || bus.wr_rdy !== 1'b1) begin
      bad++; $display("FAIL full_c1 actual rd_rdy=%0b wr_rdy=%0b required 1 1", bus.rd_rdy, bus.wr_rdy);
    end
    tick();
    bus.wr_addr = 11'h202; bus.wr_data = d2;
    @(negedge clk);
    total++;
    if (bus.wr_rdy !== 1'b0 || bus.rd_rdy !== 1'b0 || bus.sram_gwen !== 1'b0 || bus.sram_a !== 11'h200) begin
      bad++;
      $display("FAIL full_forced_drain actual wr_rdy=%0b rd_rdy=%0b gwen=%0b a=%h required 0 0 0 200",
               bus.wr_rdy, bus.rd_rdy, bus.sram_gwen, bus.sram_a);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.wr_rdy !== 1'b1) begin
      bad++; $display("FAIL full_held_write actual wr_rdy=%0b required=1", bus.wr_rdy);
    end
    tick();
    bus.wr_vld = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    drain_all("full");
    do_read(11'h200, d0, "full_rd0");
    do_read(11'h201, d1, "full_rd1");
    do_read(11'h202, d2, "full_rd2");
    $display("test_buffer_full complete");
  endtask

  task automatic test_partial_mask();
    logic [DW-1:0] old, d, exp;
    drain_all("mask");
    old = ref_mem[11'h7FF];
    d   = rnd_data();
    exp = {old[58:32], d[31:0]};
    bus.wr_vld = 1'b1; bus.wr_addr = 11'h7FF; bus.wr_data = d; bus.wr_bmask = 59'hFFFFFFFF;
    tick();
    bus.wr_vld = 1'b0;
    @(negedge clk);
    total++;
    if (bus.sram_gwen !== 1'b0 || bus.sram_a !== 11'h7FF || bus.sram_wen !== 59'h7FFFFFF00000000) begin
      bad++;
      $display("FAIL mask_wen actual gwen=%0b a=%h wen=%h required 0 7ff 7ffffff00000000", bus.sram_gwen, bus.sram_a, bus.sram_wen);
    end
    tick();
    do_read(11'h7FF, exp, "mask_rd");
    $display("test_partial_mask complete");
  endtask

  task automatic test_starve();
    drain_all("starve");
    bus.wr_vld = 1'b1; bus.wr_addr = 11'h300; bus.wr_data = rnd_data(); bus.wr_bmask = '1;
    bus.rd_vld = 1'b1; bus.rd_addr = 11'h040;
    @(negedge clk);
    total++;
    if (bus.rd_rdy !== 1'b1) begin
      bad++; $display("FAIL starve_c0 actual rd_rdy=%0b required=1", bus.rd_rdy);
    end
    tick();
    bus.wr_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bit exp_drain;
      bus.rd_addr = AW'(11'h040 + k);
`ifdef CT_SPSRAM_WB_STARVE_GUARD_EN
      exp_drain = (k == LIMIT + 1);
`else
      exp_drain = 1'b0;
`endif
      @(negedge clk);
      total++;
      if (bus.rd_rdy !== !exp_drain || bus.sram_gwen !== !exp_drain) begin
        bad++;
        $display("FAIL starve_cycle%0d actual rd_rdy=%0b gwen=%0b required %0b %0b",
                 k, bus.rd_rdy, bus.sram_gwen, !exp_drain, !exp_drain);
      end
      tick();
    end
    drain_all("starve");
    $display("test_starve complete");
  endtask

  task automatic test_back_to_back();
    drain_all("b2b");
    for (int k = 0; k < 7; k++) begin
      logic [AW-1:0] a;
      a = AW'(11'h500 + k);
      bus.rd_vld = (k < 6);
      bus.rd_addr = a;
      @(negedge clk);
      if (k < 6) begin
        total++;
        if (bus.rd_rdy !== 1'b1) begin
          bad++; $display("FAIL b2b_grant%0d actual rd_rdy=%0b required=1", k, bus.rd_rdy);
        end
      end
      if (k > 0) begin
        total++;
        if (bus.rd_data_vld !== 1'b1 || bus.rd_data !== ref_mem[a - 1'b1]) begin
          bad++;
          $display("FAIL b2b_data%0d actual vld=%0b data=%h required 1 %h", k, bus.rd_data_vld, bus.rd_data, ref_mem[a - 1'b1]);
        end
      end
      tick();
    end
    bus.rd_vld = 1'b0;
    $display("test_back_to_back complete");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.wr_vld   = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = AW'($urandom_range(0, 7));
      bus.wr_data  = rnd_data();
      bus.wr_bmask = rnd_data();
      bus.rd_vld   = 1'($urandom());
      bus.rd_addr  = AW'($urandom_range(0, 7));
      tick();
    end
    drain_all("random");
    for (int a = 0; a < 8; a++) do_read(AW'(a), ref_mem[a], "random_final");
    $display("test_random complete");
  endtask

  task automatic test_reset_mid_drain();
    drain_all("rstmid");
    bus.rd_vld = 1'b1; bus.rd_addr = 11'h010;
    bus.wr_vld = 1'b1; bus.wr_addr = 11'h600; bus.wr_data = rnd_data(); bus.wr_bmask = '1;
    tick();
    bus.wr_addr = 11'h601; bus.wr_data = rnd_data();
    tick();
    bus.wr_vld = 1'b0;
    @(negedge clk);
    total++;
    if (bus.sram_gwen !== 1'b0 || bus.wb_empty !== 1'b0 || bus.rd_data_vld !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_setup actual gwen=%0b empty=%0b vld=%0b required 0 0 1", bus.sram_gwen, bus.wb_empty, bus.rd_data_vld);
    end
    #1;
    drive_idle();
    rst = 1'b1;
    #1;
    total++;
    if (bus.rd_data_vld !== 1'b0 || bus.wb_empty !== 1'b1 || bus.sram_cen !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async actual vld=%0b empty=%0b cen=%0b required 0 1 1", bus.rd_data_vld, bus.wb_empty, bus.sram_cen);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (bus.wb_empty !== 1'b1 || bus.sram_gwen !== 1'b1 || bus.rd_data_vld !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_after%0d actual empty=%0b gwen=%0b vld=%0b required 1 1 0", c, bus.wb_empty, bus.sram_gwen, bus.rd_data_vld);
      end
      tick();
    end
    $display("test_reset_mid_drain complete");
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      logic [DW-1:0] v;
      v = rnd_data();
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    drive_idle();
    test_reset();
    test_write_hit();
    test_buffer_full();
    test_partial_mask();
    test_starve();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
